apb_clkgen_multi: RTL
=====================

# apb_clkgen_multi

Multi-channel, APB-programmable clock generator: NUM_CH independent divided-clock outputs derived from PCLK. Each channel has an enable, an idle polarity, a programmable half-period and a readable status. A global sync register realigns any subset of channels in one cycle. It sits on the peripheral APB bus as a slave and drives clocks and strobes to downstream test logic.

## Interface
- NUM_CH, 4, number of channels (1..16)
- CNT_W, 16, half-period counter width (2..30)
- ADDR_W, 12, PADDR width (≥9)
- PCLK  in  1  bus and generator clock; all state changes on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address; bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid while PREADY=1
- PREADY  out  1  transfer-complete pulse
- PSLVERR  out  1  error response, valid while PREADY=1
- CLK_OUT  out  NUM_CH  generated clocks, registered

## Operation
- Register map, channel c at base c·0x10 (c < NUM_CH):
  - CTRL +0x0 RW: bit0 EN, bit1 POL; other bits read 0.
  - HALF +0x4 RW: bits [CNT_W-1:0] half-period; upper bits ignored and read 0.
  - STATUS +0x8 RO: bit0 = CLK_OUT[c]; bits [CNT_W:1] = counter; rest 0.
- SYNC 0x100, write-only, reads 0. Bit i=1 restarts channel i. Bits ≥ NUM_CH are ignored.
- Any other address, and any write to STATUS, is an error. PSLVERR=1 and no state changes.
- Channel behaviour, per PCLK edge, in priority order:
  1. Write to the channel's HALF, write to its CTRL, or SYNC bit set: counter ← new HALF value, CLK_OUT ← new POL.
  2. EN=0: counter ← HALF, CLK_OUT ← POL.
  3. EN=1 and counter=0: CLK_OUT toggles, counter ← HALF.
  4. EN=1 and counter>0: counter ← counter−1.
- Output period = 2·(HALF+1) PCLK cycles, 50% duty. HALF=0 gives PCLK/2.
- First toggle after enable occurs HALF+1 cycles after the restart edge. The first phase level is POL.
- Channels are fully independent. A SYNC write with several bits set makes those channels phase-aligned from the same edge, provided their HALF values are equal.

## Timing
- Reset (async assert, sync release edge irrelevant): all CTRL/HALF=0, counters=0, CLK_OUT=0, PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer or mid-period: outputs go to reset values immediately. The transfer is dropped and no PREADY is issued.
- APB, all transfers take 2 access-phase cycles:
  - Edge E is the first edge with PSEL&PENABLE&!PREADY. At E:
    - a write updates the register (and the channel, per Operation item 1);
    - a read latches PRDATA;
    - PREADY←1;
    - PSLVERR←error.
  - Edge E+1: PREADY←0, PSLVERR←0. PRDATA holds its value until the next read.
  - PREADY is a single-cycle pulse. The master keeps PSEL/PENABLE high until it samples PREADY=1.
- STATUS read at E returns the values held just before edge E.
- Write to CTRL with the same EN/POL still restarts the channel (this is the restart-by-write rule).
- A write and a SYNC to the same channel cannot coincide (single bus). The SYNC/CTRL/HALF restart always overrides count and toggle on that edge.
- Counter wraps only by reload, never by underflow.

## Test plan
- Reset: PRESET pulse mid-cycle → CLK_OUT=0, PREADY=0. Read CH0 CTRL/HALF/STATUS → 0.
- CH0 HALF=3, CTRL=0x1 → CLK_OUT[0] low 4 cycles, high 4, period 8. STATUS counter steps 3,2,1,0.
- CH1 HALF=0, CTRL=0x3 → CLK_OUT[1] starts high and toggles every cycle (PCLK/2). CTRL=0x2 → holds 1.
- CH0 and CH2 HALF=5, both enabled at different times, then SYNC=0x5 → identical CLK_OUT[0]/[2] waveforms from the next edge.
- Read 0x0F0 and write 0x008 → PREADY with PSLVERR=1. Registers unchanged and CLK_OUT unaffected.
- Back-to-back transfers: PREADY pulses exactly once per transfer. PRDATA matches the register value at edge E.

Source files
------------

// File: rtl/apb_clkgen_multi.sv
// APB-programmable multi-channel clock generator: NUM_CH divided clocks from PCLK,
// each with enable, idle polarity, half-period and readable status, plus a global SYNC.
module apb_clkgen_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] CLK_OUT
);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_access;

  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_pol;
  logic [NUM_CH-1:0] r_clk;
  logic [CNT_W-1:0]  r_half [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [31:0]       r_prdata;
  logic              r_pslverr;

  logic [3:0]        w_ch_idx;
  logic [1:0]        w_reg;
  logic              w_in_ch;
  logic              w_is_sync;
  logic              w_err;
  logic              w_wr;
  logic [31:0]       w_rdata;
  logic              w_sel_en;
  logic              w_sel_pol;
  logic              w_sel_clk;
  logic [CNT_W-1:0]  w_sel_half;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic [NUM_CH-1:0] w_wr_ctrl;
  logic [NUM_CH-1:0] w_wr_half;
  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_restart;
  logic [NUM_CH-1:0] w_new_pol;
  logic [CNT_W-1:0]  w_new_half [NUM_CH];
  logic              w_unused;

  assign w_unused = ^{PADDR[1:0], PWDATA};

  // Bus handshake: one access edge, then one response cycle that blocks re-triggering
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && PENABLE) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign PREADY  = (r_state == ST_RESP);
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;
  assign CLK_OUT = r_clk;

  // Address decode; channel windows occupy 0x000-0x0FF, SYNC sits alone at 0x100
  assign w_ch_idx  = PADDR[7:4];
  assign w_reg     = PADDR[3:2];
  assign w_in_ch   = (PADDR[ADDR_W-1:8] == '0) && ({28'd0, w_ch_idx} < NUM_CH);
  assign w_is_sync = (PADDR[ADDR_W-1:8] == (ADDR_W-8)'(1)) && (PADDR[7:2] == '0);

  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_pol  = 1'b0;
    w_sel_clk  = 1'b0;
    w_sel_half = '0;
    w_sel_cnt  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_ch_idx == 4'(c)) begin
        w_sel_en   = r_en[c];
        w_sel_pol  = r_pol[c];
        w_sel_clk  = r_clk[c];
        w_sel_half = r_half[c];
        w_sel_cnt  = r_cnt[c];
      end
    end
  end

  always_comb begin
    w_err   = 1'b1;
    w_rdata = '0;
    if (w_is_sync) begin
      w_err = 1'b0;
    end else if (w_in_ch) begin
      case (w_reg)
        2'd0: begin
          w_err   = 1'b0;
          w_rdata = {30'd0, w_sel_pol, w_sel_en};
        end
        2'd1: begin
          w_err   = 1'b0;
          w_rdata = 32'(w_sel_half);
        end
        2'd2: begin
          w_err   = PWRITE;
          w_rdata = 32'({w_sel_cnt, w_sel_clk});
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_wr = w_access && PWRITE && !w_err;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_wr_ctrl[c]  = w_wr && w_in_ch && (w_ch_idx == 4'(c)) && (w_reg == 2'd0);
      w_wr_half[c]  = w_wr && w_in_ch && (w_ch_idx == 4'(c)) && (w_reg == 2'd1);
      w_sync[c]     = w_wr && w_is_sync && PWDATA[c];
      w_restart[c]  = w_wr_ctrl[c] || w_wr_half[c] || w_sync[c];
      w_new_half[c] = w_wr_half[c] ? PWDATA[CNT_W-1:0] : r_half[c];
      w_new_pol[c]  = w_wr_ctrl[c] ? PWDATA[1] : r_pol[c];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (w_access) begin
      r_pslverr <= w_err;
      if (!PWRITE && !w_err) r_prdata <= w_rdata;
    end else begin
      r_pslverr <= 1'b0;
    end
  end

  // Restart (register write or SYNC) takes priority over counting and toggling
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_en  <= '0;
      r_pol <= '0;
      r_clk <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_half[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_wr_ctrl[c]) begin
          r_en[c]  <= PWDATA[0];
          r_pol[c] <= PWDATA[1];
        end
        if (w_wr_half[c]) r_half[c] <= PWDATA[CNT_W-1:0];
        if (w_restart[c]) begin
          r_cnt[c] <= w_new_half[c];
          r_clk[c] <= w_new_pol[c];
        end else if (!r_en[c]) begin
          r_cnt[c] <= r_half[c];
          r_clk[c] <= r_pol[c];
        end else if (r_cnt[c] == '0) begin
          r_clk[c] <= ~r_clk[c];
          r_cnt[c] <= r_half[c];
        end else begin
          r_cnt[c] <= r_cnt[c] - 1'b1;
        end
      end
    end
  end

endmodule
